// File: rtl/processor_multiport.sv
// Two-cycle (FETCH/EXEC) 12-bit accumulator-style processor with a multiport
// register file, 16-word instruction memory and a debug register read port.
//
// state | meaning
// IDLE  | after reset, waiting for start; imem writable
// FETCH | IR <= imem[PC], PC <= PC+1 (mod 16)
// EXEC  | register write, Z update, taken-branch PC update
// HALT  | program finished; imem writable, start reruns from PC reset value
module processor_multiport #(
  parameter int reg_width      = 12,
  parameter int reg_count      = 16,
  parameter int reg_file_count = 11,
  parameter int IR_width       = 12,
  parameter int Im_width       = 8,
  parameter logic [reg_width-1:0] current_PC_value = 12'h000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         imem_we,
  input  logic [$clog2(reg_count)-1:0] imem_addr,
  input  logic [IR_width-1:0]          imem_wdata,
  input  logic [3:0]                   dbg_addr,
  output logic [reg_width-1:0]         dbg_data,
  output logic [reg_width-1:0]         pc_out,
  output logic                         busy,
  output logic                         done
);

  localparam int AW = $clog2(reg_count);
  localparam logic [reg_width-1:0] ONE = reg_width'(1);

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_INC  = 4'h8;
  localparam logic [3:0] OP_DEC  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JNZ  = 4'hC;
  localparam logic [3:0] OP_NOT  = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [reg_width-1:0]   pc_q, pc_d;
  logic [IR_width-1:0]    ir_q, ir_d;
  logic                   z_q, z_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [reg_width-1:0]   regs_q [reg_file_count];
  logic [reg_width-1:0]   regs_d [reg_file_count];
  logic [IR_width-1:0]    imem_q [reg_count];
  logic [IR_width-1:0]    imem_d [reg_count];

  logic [3:0]             op;
  logic [3:0]             rd_idx;
  logic [3:0]             rs_idx;
  logic [Im_width-1:0]    imm;
  logic [reg_width-1:0]   rd_val;
  logic [reg_width-1:0]   rs_val;
  logic [reg_width-1:0]   alu_res;
  logic [3:0]             wr_idx;
  logic                   wr_en;
  logic                   br_taken;
  logic                   prog_phase;

  assign op     = ir_q[IR_width-1:IR_width-4];
  assign rd_idx = ir_q[7:4];
  assign rs_idx = ir_q[3:0];
  assign imm    = ir_q[Im_width-1:0];

  // Indices past the implemented registers read as zero on every port.
  assign rd_val   = (int'(rd_idx)   < reg_file_count) ? regs_q[rd_idx]   : '0;
  assign rs_val   = (int'(rs_idx)   < reg_file_count) ? regs_q[rs_idx]   : '0;
  assign dbg_data = (int'(dbg_addr) < reg_file_count) ? regs_q[dbg_addr] : '0;

  assign pc_out     = pc_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign prog_phase = (state_q == S_IDLE) || (state_q == S_HALT);

  always_comb begin
    alu_res = '0;
    wr_idx  = rd_idx;
    wr_en   = 1'b1;
    case (op)
      OP_LDI: begin
        alu_res = {{(reg_width-Im_width){1'b0}}, imm};
        wr_idx  = 4'd0;
      end
      OP_MOV:  alu_res = rs_val;
      OP_ADD:  alu_res = rd_val + rs_val;
      OP_SUB:  alu_res = rd_val - rs_val;
      OP_AND:  alu_res = rd_val & rs_val;
      OP_OR:   alu_res = rd_val | rs_val;
      OP_XOR:  alu_res = rd_val ^ rs_val;
      OP_INC:  alu_res = rd_val + ONE;
      OP_DEC:  alu_res = rd_val - ONE;
      OP_NOT:  alu_res = ~rd_val;
      default: wr_en   = 1'b0;
    endcase
  end

  assign br_taken = (op == OP_JMP) || ((op == OP_JZ) && z_q) || ((op == OP_JNZ) && !z_q);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    regs_d  = regs_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = current_PC_value;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = imem_q[pc_q[AW-1:0]];
        pc_d    = {{(reg_width-AW){1'b0}}, pc_q[AW-1:0] + AW'(1)};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Z follows every result-producing opcode, even when the write is dropped.
        if (wr_en) begin
          z_d = (alu_res == '0);
          if (int'(wr_idx) < reg_file_count) begin
            regs_d[wr_idx] = alu_res;
          end
        end
        if (br_taken) begin
          pc_d = {{(reg_width-AW){1'b0}}, imm[AW-1:0]};
        end
        state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d == S_FETCH) || (state_d == S_EXEC);
  assign done_d = (state_d == S_HALT);

  always_comb begin
    imem_d = imem_q;
    if (imem_we && prog_phase) begin
      imem_d[imem_addr] = imem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= current_PC_value;
      ir_q    <= '0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      regs_q  <= regs_d;
    end
  end

  // Program memory keeps its contents through reset.
  always_ff @(posedge clk) begin
    imem_q <= imem_d;
  end

endmodule

// File: tb/tb_processor_multiport.sv
// Bench for processor_multiport: directed programs plus random forward-branching
// programs, all compared against an instruction-level reference model.
module tb_processor_multiport;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        imem_we = 1'b0;
  logic [3:0]  imem_addr = '0;
  logic [11:0] imem_wdata = '0;
  logic [3:0]  dbg_addr = '0;
  logic [11:0] dbg_data;
  logic [11:0] pc_out;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  int m_r [11];
  bit m_z;
  int m_mem [16];
  int m_cycles;
  int m_pc;

  processor_multiport dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .pc_out    (pc_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rf(input int i);
    return (i < 11) ? m_r[i] : 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 11; i++) m_r[i] = 0;
    m_z = 1'b0;
  endfunction

  // Executes m_mem from address 0 until HALT, one instruction per step.
  function automatic void model_run();
    int pc, w, op, d, s, imm, res;
    bit writes;
    pc = 0;
    m_cycles = 0;
    for (int step = 0; step < 500; step++) begin
      w = m_mem[pc];
      pc = (pc + 1) % 16;
      m_cycles += 2;
      op = (w >> 8) & 15;
      d = (w >> 4) & 15;
      s = w & 15;
      imm = w & 255;
      writes = 1'b1;
      res = 0;
      case (op)
        1:  begin res = imm; d = 0; end
        2:  res = rf(s);
        3:  res = (rf(d) + rf(s)) % 4096;
        4:  res = (rf(d) - rf(s) + 4096) % 4096;
        5:  res = rf(d) & rf(s);
        6:  res = rf(d) | rf(s);
        7:  res = rf(d) ^ rf(s);
        8:  res = (rf(d) + 1) % 4096;
        9:  res = (rf(d) + 4095) % 4096;
        13: res = 4095 - rf(d);
        default: writes = 1'b0;
      endcase
      if (writes) begin
        if (d < 11) m_r[d] = res;
        m_z = (res == 0);
      end
      if (op == 10 || (op == 11 && m_z) || (op == 12 && !m_z)) pc = imm % 16;
      if (op == 15) break;
    end
    m_pc = pc;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      imem_we = 1'b1;
      imem_addr = 4'(i);
      imem_wdata = 12'(m_mem[i]);
    end
    @(negedge clk);
    imem_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic check_reg(input string tag, input int idx, input int val);
    dbg_addr = 4'(idx);
    #1;
    check(tag, 32'(dbg_data), 32'(val));
  endtask

  // disturb: mid-run, hold start high and attempt an imem write for one edge.
  task automatic run_prog(input string tag, input bit disturb);
    int cyc;
    model_run();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 1200) begin
      cyc++;
      if (disturb && cyc == 3) begin
        start = 1'b1;
        imem_we = 1'b1;
        imem_addr = 4'd0;
        imem_wdata = 12'hFFF;
      end else begin
        start = 1'b0;
        imem_we = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    imem_we = 1'b0;
    check({tag, "_cycles"}, 32'(cyc), 32'(m_cycles));
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pc"}, 32'(pc_out), 32'(m_pc));
    for (int i = 0; i < 16; i++) check_reg($sformatf("%s_r%0d", tag, i), i, rf(i));
  endtask

  initial begin
    int op, w;
    #2;
    reset = 1'b0;
    #20;
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) check_reg($sformatf("rst_r%0d", i), i, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();

    clear_mem();
    m_mem[0] = 'h105; m_mem[1] = 'h210; m_mem[2] = 'h310; m_mem[3] = 'hF00;
    load_prog();
    run_prog("basic", 1'b0);
    check("basic_cyc8", 32'(m_cycles), 32'd8);
    check_reg("basic_R0", 0, 'h005);
    check_reg("basic_R1", 1, 'h00A);
    check("basic_pc4", 32'(pc_out), 32'd4);
    run_prog("basic_again", 1'b1);
    check_reg("basic_again_R1", 1, 'h00A);

    clear_mem();
    m_mem[0] = 'h101; m_mem[1] = 'h210; m_mem[2] = 'h100; m_mem[3] = 'h401; m_mem[4] = 'hF00;
    load_prog();
    run_prog("wrapval", 1'b0);
    check_reg("wrapval_R0", 0, 'hFFF);
    check_reg("wrapval_R1", 1, 'h001);

    clear_mem();
    m_mem[0] = 'h103; m_mem[1] = 'h900; m_mem[2] = 'hB04; m_mem[3] = 'hA01; m_mem[4] = 'hF00;
    load_prog();
    run_prog("loop", 1'b0);
    check_reg("loop_R0", 0, 'h000);
    check("loop_cycles20", 32'(m_cycles), 32'd20);

    clear_mem();
    m_mem[0] = 'h107; m_mem[1] = 'h2C0; m_mem[2] = 'hF00;
    load_prog();
    run_prog("badreg", 1'b0);
    check_reg("badreg_R12", 12, 0);
    check_reg("badreg_R0", 0, 'h007);

    // PC runs off the end at 15 and continues from 0 on the second pass.
    clear_mem();
    m_mem[0] = 'h810; m_mem[1] = 'h221; m_mem[2] = 'h920; m_mem[3] = 'hC05;
    m_mem[4] = 'hA0E; m_mem[5] = 'hF00; m_mem[14] = 'h830; m_mem[15] = 'h000;
    do_reset();
    load_prog();
    run_prog("pcwrap", 1'b0);
    check_reg("pcwrap_R1", 1, 2);
    check_reg("pcwrap_R3", 3, 1);
    check("pcwrap_pc", 32'(pc_out), 32'd6);

    clear_mem();
    m_mem[0] = 'h105; m_mem[1] = 'h210; m_mem[2] = 'h310; m_mem[3] = 'hF00;
    load_prog();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_pc", 32'(pc_out), 32'd0);
    check_reg("midrst_R0", 0, 0);
    check_reg("midrst_R1", 1, 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run_prog("midrst_rerun", 1'b0);
    check_reg("midrst_rerun_R0", 0, 'h005);
    check_reg("midrst_rerun_R1", 1, 'h00A);

    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 3) == 0) do_reset();
      for (int a = 0; a < 16; a++) begin
        op = (a == 15) ? 15 : int'($urandom_range(0, 15));
        if (op == 15 && a != 15 && $urandom_range(0, 3) != 0) op = 8;
        if (op >= 10 && op <= 12)
          w = (op << 8) | (int'($urandom_range(0, 15)) << 4) | int'($urandom_range(a + 1, 15));
        else
          w = (op << 8) | int'($urandom_range(0, 255));
        m_mem[a] = w;
      end
      load_prog();
      run_prog($sformatf("rnd%0d", t), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/processor_multiport.md
PROCESSOR_MULTIPORT -- requirements
Module: processor_multiport

Interface
REQ-001 Parameters SHALL be:
- reg_width, 12, datapath, register and PC width
- reg_count, 16, instruction-memory depth
- reg_file_count, 11, number of general registers R0..R10
- IR_width, 12, instruction width
- Im_width, 8, immediate width
- current_PC_value, 12'h000, PC value after reset and on every start
REQ-002 Ports SHALL be (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- start  in  1  run request
- imem_we  in  1  instruction-memory write enable
- imem_addr  in  4  instruction-memory write address
- imem_wdata  in  12  instruction-memory write data
- dbg_addr  in  4  register-file debug read address
- dbg_data  out  12  register-file debug read data
- pc_out  out  12  current PC
- busy  out  1  high in FETCH/EXEC
- done  out  1  high in HALT

Function
REQ-003 Register file SHALL be multiport: two combinational read ports (rd, rs), one debug read port (dbg_addr) and one synchronous write port.
REQ-004 Register indices 11..15 SHALL read as 0; writes to them SHALL be discarded.
REQ-005 dbg_data SHALL be a combinational read of R[dbg_addr].
REQ-006 Instruction format SHALL be op=[11:8], rd=[7:4], rs=[3:0], imm=[7:0].
REQ-007 Opcodes SHALL behave as follows; all arithmetic is modulo 2^12:
- 0 NOP
- 1 LDI: R0<=zero-extended imm
- 2 MOV: Rd<=Rs
- 3 ADD: Rd<=Rd+Rs
- 4 SUB: Rd<=Rd-Rs
- 5 AND
- 6 OR
- 7 XOR
- 8 INC: Rd+1
- 9 DEC: Rd-1
- A JMP: PC<=imm mod 16
- B JZ: jump if Z=1
- C JNZ: jump if Z=0
- D NOT: Rd<=~Rd
- E NOP
- F HALT
REQ-008 Z flag SHALL update to (result==0) on opcodes 1-9 and D, including when rd is 11..15; other opcodes SHALL leave Z unchanged.
REQ-009 FSM states SHALL be IDLE, FETCH, EXEC and HALT.
REQ-010 In IDLE or HALT, start=1 at a rising edge SHALL load PC<=current_PC_value, clear done and enter FETCH; start SHALL be ignored in FETCH and EXEC.
REQ-011 FETCH SHALL load IR<=imem[PC[3:0]] and PC<=(PC+1) mod 16, then enter EXEC.
REQ-012 EXEC SHALL perform the register write, Z update and taken-branch PC update, then enter FETCH; HALT instead enters HALT.
REQ-013 Each instruction SHALL take exactly 2 cycles; PC wraps from 15 to 0.
REQ-014 imem SHALL be written on rising clk when imem_we=1 in IDLE or HALT only; writes in FETCH/EXEC SHALL be ignored.
REQ-015 pc_out SHALL equal the PC register; busy and done SHALL be registered state decodes.

Reset
REQ-016 reset=0 SHALL immediately force state IDLE, PC=current_PC_value, IR=0, all registers 0, Z=0, busy=0 and done=0, regardless of clock or current state.
REQ-017 imem contents SHALL NOT be affected by reset.
REQ-018 Reset asserted mid-run SHALL abort the instruction in flight with no register write.

Verification
REQ-019 Reset: reset=0 -> pc_out=0, busy=0, done=0, dbg_data=0 for dbg_addr 0..15.
REQ-020 Basic program: imem 0..3 = 0x105, 0x210, 0x310, 0xF00; pulse start -> busy for 8 cycles after the start edge, then done=1, R0=0x005, R1=0x00A, pc_out=4.
REQ-021 Wrap: imem = 0x101, 0x210, 0x100, 0x401, 0xF00 -> R0=0xFFF, R1=0x001, Z=0, done=1.
REQ-022 Loop: imem = 0x103, 0x900, 0xB04, 0xA01, 0xF00 -> R0=0x000, done=1 after 3 loop iterations.
REQ-023 Invalid register: imem = 0x107, 0x2C0, 0xF00 -> dbg_addr=12 reads 0x000, R0=0x007.
REQ-024 Mid-run reset: pull reset low during EXEC of the REQ-020 program -> registers 0, IDLE; after release, start reruns the program to the same REQ-020 result.
